clarvi_part_regfile: RTL and testbench
======================================

Name: clarvi_part_regfile

Overview:
- Parametrised successor to the fixed 2-read, 64-bit split register file.
- Configurable register count, register width, part (slice) width and read-port count.
- Reads are registered (1-cycle, BRAM-friendly); a post-reset clear sequencer zeroes storage.
- Sits between decode (read ports) and writeback (write port) in multi-part execution pipelines.

Parameters:
NUM_REGS, 32, number of architectural registers; power of two, >=2
REG_WIDTH, 64, bits per register; integer multiple of PART_WIDTH
PART_WIDTH, 32, bits per read/write slice
NUM_READ_PORTS, 2, independent read ports, >=1
Derived: PARTS=REG_WIDTH/PART_WIDTH; AW=$clog2(NUM_REGS); PW=max(1,$clog2(PARTS))

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
ready  output  1  high once clear sequence done; write and read ports valid
rd_addr  input  NUM_READ_PORTS*AW  read register index, port i at [i*AW +: AW]
rd_part  input  NUM_READ_PORTS*PW  part index per port
rd_data  output  NUM_READ_PORTS*PART_WIDTH  registered read data per port
wr_en  input  1  write strobe
wr_addr  input  AW  write register index
wr_part  input  PW  part index written
wr_data  input  PART_WIDTH  write data
wr_accept  output  1  combinational: wr_en && ready && wr_addr!=0 && wr_part<PARTS

Behaviour:
- Storage: NUM_REGS x REG_WIDTH array, no reset on the array itself.
- FSM states CLEAR, RUN. Async reset -> CLEAR, clear counter=0, ready=0, all rd_data=0.
- CLEAR: each cycle write 0 to all parts of register[counter], counter++. Leave to RUN after counter==NUM_REGS-1 is written (exactly NUM_REGS cycles). ready asserts first cycle in RUN.
- During CLEAR: wr_en ignored (wr_accept=0); rd_data held at 0.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to CLEAR, counter restarts at 0, ready drops asynchronously.
- RUN write: when wr_accept, registers[wr_addr][wr_part*PART_WIDTH +: PART_WIDTH] <= wr_data; other parts untouched.
- Writes to register 0 are dropped. Writes with wr_part>=PARTS are dropped.
- RUN read: rd_data[i] at edge N+1 reflects rd_addr[i]/rd_part[i] sampled at edge N (latency 1). rd_addr==0 -> 0. rd_part>=PARTS -> 0.
- All read ports independent; identical addresses on several ports return identical data.
- Read-write collision (same addr, same part, same edge): see Optional Feature. Same addr, different part: reads stored part value unaffected.
- debug/aux ports absent; no stall output other than ready.

Optional Feature:
- Macro CLARVI_REGFILE_BYPASS_EN.
- Defined: on collision (rd_addr==wr_addr, rd_part==wr_part, wr_accept) the port returns wr_data next cycle (write-first). Register 0 still reads 0.
- Undefined: collision returns the old stored value (read-first, pure BRAM semantics).

Test Plan:
- Reset, hold 40 cycles, defaults -> ready low for exactly 32 cycles after reset release, high from cycle 33; all rd_data 0 throughout.
- Write reg5 part0=0xDEADBEEF, part1=0x12345678; read port0 reg5 part1, port1 reg5 part0 -> next cycle 0x12345678 and 0xDEADBEEF.
- Write reg0 part0=0xFFFFFFFF -> wr_accept=0; read reg0 -> 0x00000000.
- Write reg7 part0=0xA5A5A5A5 while port0 reads reg7 part0 same edge -> 0xA5A5A5A5 with BYPASS_EN, prior value (0 after clear) without; port1 reading reg7 part1 -> 0.
- Fill reg31 with 0x1, assert reset for 1 cycle mid-RUN, wait ready -> reg31 reads 0; assert reset again at clear cycle 10 -> ready returns only 32 cycles after the second release.
- NUM_REGS=16, REG_WIDTH=96, NUM_READ_PORTS=3: write parts 0..2 of reg15 with 1,2,3; read all three ports -> 1,2,3; rd_part=3 -> 0.

Source files
------------

// File: rtl/clarvi_part_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : clarvi_part_regfile
//  Description : Parametrised, part-sliced register file. Each register is
//                REG_WIDTH bits wide and is read and written one PART_WIDTH
//                slice at a time. Reads are registered, giving one cycle of
//                latency. After reset a clear sequencer zeroes one register
//                per cycle. While it runs, ready is low, writes are ignored
//                and read data is held at zero.
//
//  Ports       : clock      - system clock, all state on the rising edge
//                reset      - asynchronous, active-high reset
//                ready      - high once the clear sequence has completed
//                rd_addr    - per-port read register index, [i*AW +: AW]
//                rd_part    - per-port read part index,     [i*PW +: PW]
//                rd_data    - per-port registered read data
//                wr_en      - write strobe
//                wr_addr    - write register index
//                wr_part    - write part index
//                wr_data    - write data
//                wr_accept  - write will be committed at the next edge
//
//  Option      : CLARVI_REGFILE_BYPASS_EN - when defined, a read that hits the
//                slice being written on the same edge returns the new data
//                (write-first). When undefined, it returns the old data
//                (read-first, plain BRAM behaviour).
//
//  Revision    : 1.0 - initial release
// ============================================================================
module clarvi_part_regfile #(
   parameter int NUM_REGS       = 32,
   parameter int REG_WIDTH      = 64,
   parameter int PART_WIDTH     = 32,
   parameter int NUM_READ_PORTS = 2,
   localparam int PARTS = REG_WIDTH / PART_WIDTH,
   localparam int AW    = $clog2(NUM_REGS),
   localparam int PW    = (PARTS > 1) ? $clog2(PARTS) : 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   output logic                                 ready,
   input  logic [NUM_READ_PORTS*AW-1:0]         rd_addr,
   input  logic [NUM_READ_PORTS*PW-1:0]         rd_part,
   output logic [NUM_READ_PORTS*PART_WIDTH-1:0] rd_data,
   input  logic                                 wr_en,
   input  logic [AW-1:0]                        wr_addr,
   input  logic [PW-1:0]                        wr_part,
   input  logic [PART_WIDTH-1:0]                wr_data,
   output logic                                 wr_accept
);

   // One bit per encodable part index, set where that index names a real
   // part. This avoids a range compare that is constant when PARTS is a
   // power of two.
   localparam int            PART_IDX_N   = 1 << PW;
   localparam logic [PART_IDX_N-1:0] C_PART_VALID =
      PART_IDX_N'((64'(1) << PARTS) - 64'(1));

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [AW-1:0]          r_clear_cnt;
   logic [AW-1:0]          w_clear_cnt_next;
   logic                   w_wr_part_ok;

   // Storage has no reset. The clear sequencer initialises it instead.
   logic [PARTS-1:0][PART_WIDTH-1:0] r_mem [NUM_REGS];

   // ------------------------------------------------------------------------
   // Clear sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_CLEAR;
         r_clear_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_clear_cnt <= w_clear_cnt_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_clear_cnt_next = r_clear_cnt;
      case (r_state)
         S_CLEAR: begin
            w_clear_cnt_next = r_clear_cnt + AW'(1);
            if (r_clear_cnt == AW'(NUM_REGS - 1)) begin
               w_state_next = S_RUN;
            end
         end
         default: begin
            w_state_next = S_RUN;
         end
      endcase
   end

   // Decoded straight from the state register, so an asynchronous reset
   // drops ready without waiting for a clock edge.
   assign ready = (r_state == S_RUN);

   // ------------------------------------------------------------------------
   // Write port
   // ------------------------------------------------------------------------
   assign w_wr_part_ok = C_PART_VALID[wr_part];
   assign wr_accept    = wr_en && ready && (wr_addr != '0) && w_wr_part_ok;

   always_ff @(posedge clock) begin
      if (!ready) begin
         r_mem[r_clear_cnt] <= '0;
      end else if (wr_accept) begin
         r_mem[wr_addr][wr_part] <= wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd_port
      logic [AW-1:0]         w_addr;
      logic [PW-1:0]         w_part;
      logic                  w_part_ok;
      logic                  w_bypass;
      logic [PART_WIDTH-1:0] r_data;

      assign w_addr    = rd_addr[gi*AW +: AW];
      assign w_part    = rd_part[gi*PW +: PW];
      assign w_part_ok = C_PART_VALID[w_part];

`ifdef CLARVI_REGFILE_BYPASS_EN
      // wr_accept already excludes register 0, so a bypass never
      // overrides the hard-wired zero.
      assign w_bypass = wr_accept && (wr_addr == w_addr) && (wr_part == w_part);
`else
      assign w_bypass = 1'b0;
`endif

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_data <= '0;
         end else if (!ready || (w_addr == '0) || !w_part_ok) begin
            r_data <= '0;
         end else if (w_bypass) begin
            r_data <= wr_data;
         end else begin
            r_data <= r_mem[w_addr][w_part];
         end
      end

      assign rd_data[gi*PART_WIDTH +: PART_WIDTH] = r_data;
   end

endmodule
`default_nettype wire

// File: tb/tb_clarvi_part_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clarvi_part_regfile
//  Description : Directed self-checking bench for clarvi_part_regfile. It
//                drives a default instance (32 x 64, 2 ports) and a wide
//                instance (16 x 96, 3 ports), which share the clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clarvi_part_regfile;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   // Default instance: AW=5, PW=1, 2 ports.
   logic        ready_a;
   logic [9:0]  rd_addr_a = '0;
   logic [1:0]  rd_part_a = '0;
   logic [63:0] rd_data_a;
   logic        wr_en_a   = 1'b0;
   logic [4:0]  wr_addr_a = '0;
   logic        wr_part_a = 1'b0;
   logic [31:0] wr_data_a = '0;
   logic        wr_accept_a;

   // Wide instance: AW=4, PARTS=3, PW=2, 3 ports.
   logic        ready_b;
   logic [11:0] rd_addr_b = '0;
   logic [5:0]  rd_part_b = '0;
   logic [95:0] rd_data_b;
   logic        wr_en_b   = 1'b0;
   logic [3:0]  wr_addr_b = '0;
   logic [1:0]  wr_part_b = '0;
   logic [31:0] wr_data_b = '0;
   logic        wr_accept_b;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clock = ~clock;

   clarvi_part_regfile dut_a (
      .clock     (clock),
      .reset     (reset),
      .ready     (ready_a),
      .rd_addr   (rd_addr_a),
      .rd_part   (rd_part_a),
      .rd_data   (rd_data_a),
      .wr_en     (wr_en_a),
      .wr_addr   (wr_addr_a),
      .wr_part   (wr_part_a),
      .wr_data   (wr_data_a),
      .wr_accept (wr_accept_a)
   );

   clarvi_part_regfile #(
      .NUM_REGS       (16),
      .REG_WIDTH      (96),
      .PART_WIDTH     (32),
      .NUM_READ_PORTS (3)
   ) dut_b (
      .clock     (clock),
      .reset     (reset),
      .ready     (ready_b),
      .rd_addr   (rd_addr_b),
      .rd_part   (rd_part_b),
      .rd_data   (rd_data_b),
      .wr_en     (wr_en_b),
      .wr_addr   (wr_addr_b),
      .wr_part   (wr_part_b),
      .wr_data   (wr_data_b),
      .wr_accept (wr_accept_b)
   );

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge. Returns one negedge later with the strobe dropped.
   task automatic wr_a(input logic [4:0] a, input logic p, input logic [31:0] d);
      wr_en_a = 1'b1; wr_addr_a = a; wr_part_a = p; wr_data_a = d;
      @(negedge clock);
      wr_en_a = 1'b0;
   endtask

   task automatic wr_b(input logic [3:0] a, input logic [1:0] p, input logic [31:0] d);
      wr_en_b = 1'b1; wr_addr_b = a; wr_part_b = p; wr_data_b = d;
      @(negedge clock);
      wr_en_b = 1'b0;
   endtask

   initial begin
      // ---- reset and clear sequence ----------------------------------------
      rd_addr_a = {5'd4, 5'd3};          // port1 reg4, port0 reg3
      wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_part_a = 1'b0; wr_data_a = 32'h55;
      repeat (40) @(negedge clock);
      check("rst_ready_a", ready_a, 0);
      check("rst_ready_b", ready_b, 0);
      check("rst_rd_data_a", rd_data_a, 0);
      check("rst_rd_data_b", rd_data_b, 0);
      check("rst_wr_accept", wr_accept_a, 0);
      reset = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         check("clr_ready_a", ready_a, k >= 32);
         check("clr_ready_b", ready_b, k >= 16);
         if (k < 32) begin
            check("clr_rd_zero", rd_data_a, 0);
            check("clr_wr_accept", wr_accept_a, 0);
         end
         if (k == 32) wr_en_a = 1'b0;
      end
      check("clr_wr_dropped", rd_data_a[31:0], 0);

      // ---- split write / cross read ----------------------------------------
      wr_a(5'd5, 1'b0, 32'hDEADBEEF);
      wr_a(5'd5, 1'b1, 32'h12345678);
      rd_addr_a = {5'd5, 5'd5};
      rd_part_a = {1'b0, 1'b1};          // port1 part0, port0 part1
      @(negedge clock);
      check("rd5_p0_part1", rd_data_a[31:0], 32'h12345678);
      check("rd5_p1_part0", rd_data_a[63:32], 32'hDEADBEEF);

      // ---- register 0 is hard zero -----------------------------------------
      wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_part_a = 1'b0; wr_data_a = 32'hFFFFFFFF;
      #1 check("wr0_accept", wr_accept_a, 0);
      @(negedge clock);
      wr_en_a = 1'b0;
      rd_addr_a = {5'd0, 5'd0};
      rd_part_a = {1'b1, 1'b0};
      @(negedge clock);
      check("rd0_p0", rd_data_a[31:0], 0);
      check("rd0_p1", rd_data_a[63:32], 0);

      // ---- read/write collision --------------------------------------------
      wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_part_a = 1'b0; wr_data_a = 32'hA5A5A5A5;
      rd_addr_a = {5'd7, 5'd7};
      rd_part_a = {1'b1, 1'b0};          // port1 part1, port0 part0
      #1 check("wr7_accept", wr_accept_a, 1);
      @(negedge clock);
      wr_en_a = 1'b0;
`ifdef CLARVI_REGFILE_BYPASS_EN
      check("coll_p0", rd_data_a[31:0], 32'hA5A5A5A5);
`else
      check("coll_p0", rd_data_a[31:0], 32'h0);
`endif
      check("coll_p1_other_part", rd_data_a[63:32], 0);
      @(negedge clock);
      check("after_coll_p0", rd_data_a[31:0], 32'hA5A5A5A5);

      // ---- reset mid-RUN clears storage ------------------------------------
      wr_a(5'd31, 1'b0, 32'h1);
      wr_a(5'd31, 1'b1, 32'h1);
      rd_addr_a = {5'd31, 5'd31};
      rd_part_a = {1'b1, 1'b0};
      @(negedge clock);
      check("rd31_p0_filled", rd_data_a[31:0], 32'h1);
      check("rd31_p1_filled", rd_data_a[63:32], 32'h1);
      reset = 1'b1;
      #1 check("async_ready_drop", ready_a, 0);
      check("async_rd_zero", rd_data_a, 0);
      @(negedge clock);
      reset = 1'b0;
      n = 0;
      while (!ready_a && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("rerun_clear_len", n, 32);
      @(negedge clock);
      check("rd31_p0_cleared", rd_data_a[31:0], 0);
      check("rd31_p1_cleared", rd_data_a[63:32], 0);

      // ---- reset again at clear cycle 10 -----------------------------------
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      check("midclr_ready", ready_a, 0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      n = 0;
      while (!ready_a && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("midclr_clear_len", n, 32);
      check("midclr_ready_b", ready_b, 1);

      // ---- wide, three-port instance ---------------------------------------
      wr_en_b = 1'b1; wr_addr_b = 4'd15; wr_part_b = 2'd0; wr_data_b = 32'd1;
      #1 check("b_wr_accept", wr_accept_b, 1);
      @(negedge clock);
      wr_en_b = 1'b0;
      wr_b(4'd15, 2'd1, 32'd2);
      wr_b(4'd15, 2'd2, 32'd3);
      wr_en_b = 1'b1; wr_addr_b = 4'd15; wr_part_b = 2'd3; wr_data_b = 32'hFF;
      #1 check("b_wr_part3_accept", wr_accept_b, 0);
      @(negedge clock);
      wr_en_b = 1'b0;
      rd_addr_b = {4'd15, 4'd15, 4'd15};
      rd_part_b = {2'd2, 2'd1, 2'd0};
      @(negedge clock);
      check("b_p0", rd_data_b[31:0], 32'd1);
      check("b_p1", rd_data_b[63:32], 32'd2);
      check("b_p2", rd_data_b[95:64], 32'd3);
      rd_part_b = {2'd2, 2'd1, 2'd3};
      @(negedge clock);
      check("b_p0_part3", rd_data_b[31:0], 0);
      check("b_p1_again", rd_data_b[63:32], 32'd2);
      check("b_p2_again", rd_data_b[95:64], 32'd3);
      rd_part_b = {2'd1, 2'd1, 2'd1};
      @(negedge clock);
      check("b_same_p0", rd_data_b[31:0], 32'd2);
      check("b_same_p1", rd_data_b[63:32], 32'd2);
      check("b_same_p2", rd_data_b[95:64], 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
